sc_mul_seq: RTL and testbench

Sequential, parametrised stochastic-computing multiplier with dynamic-range normalisation. It accepts two unsigned operands over a valid/ready handshake and normalises each by its leading-zero count. The top `VALID_BITS` bits of each operand are converted into unary/low-discrepancy bitstreams. It ANDs the streams over a programmable stream length, counts ones, and rescales the count to a full-width product. It sits in the SC processing-element datapath as the multi-cycle successor of the combinational SC multiply, and adds an early-termination mode.

---
 rtl/sc_pkg.sv | 26 ++
 rtl/sc_lzc.sv | 21 ++
 rtl/sc_mul_seq.sv | 131 +++++++++++++
 tb/tb_sc_mul_seq.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and helpers for the sequential stochastic-computing multiplier.
package sc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_OUT  = 2'd3
  } sc_state_e;

  // Bits needed to hold a leading-zero count of 0..w inclusive.
  function automatic int lz_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Reverses the low n bits of x; the van der Corput order decorrelates the B stream from A.
  function automatic logic [31:0] bit_rev(input logic [31:0] x, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) r[i] = x[n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module sc_lzc
  import sc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]           data_i,
  output logic [lz_width(WIDTH)-1:0] count_o
);

  localparam int LZW = lz_width(WIDTH);

  // Scanning upward lets the highest set bit have the final say.
  always_comb begin
    count_o = LZW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) count_o = LZW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/sc_mul_seq.sv
// Sequential stochastic-computing multiplier with leading-zero normalisation of both
// operands, optional early termination, and a registered full-width rescaled product.
module sc_mul_seq
  import sc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int VALID_BITS = 6,
  parameter int EARLY_TERM = 0,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_result,
  output sc_state_e             dbg_state_o
);

  localparam int LZW        = lz_width(DATA_WIDTH);
  localparam int STREAM_LEN = 1 << VALID_BITS;
  localparam int SHIFT_BASE = 2 * DATA_WIDTH - VALID_BITS;
  localparam logic [VALID_BITS:0] CNT_ONE = {{VALID_BITS{1'b0}}, 1'b1};

  sc_state_e               state_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [VALID_BITS-1:0]   ma_q, mb_q;
  logic [LZW-1:0]          lza_q, lzb_q;
  logic [VALID_BITS:0]     cnt_q, ones_q;
  logic                    in_ready_q, out_valid_q;
  logic [OUT_WIDTH-1:0]    result_q;

  logic [LZW-1:0]          lza_d, lzb_d;
  logic [DATA_WIDTH-1:0]   a_norm, b_norm;
  logic [VALID_BITS-1:0]   ma_d, mb_d, cnt_rev;
  logic                    bit_a, bit_b, last_run;
  logic [VALID_BITS:0]     ones_d, run_limit;
  logic [OUT_WIDTH-1:0]    result_d;
  int                      shift_amt;

  sc_lzc #(.WIDTH(DATA_WIDTH)) u_lzc_a (.data_i(a_q), .count_o(lza_d));
  sc_lzc #(.WIDTH(DATA_WIDTH)) u_lzc_b (.data_i(b_q), .count_o(lzb_d));

  always_comb begin
    a_norm    = a_q << lza_d;
    b_norm    = b_q << lzb_d;
    ma_d      = VALID_BITS'(a_norm >> (DATA_WIDTH - VALID_BITS));
    mb_d      = VALID_BITS'(b_norm >> (DATA_WIDTH - VALID_BITS));
    cnt_rev   = VALID_BITS'(bit_rev(32'(cnt_q[VALID_BITS-1:0]), VALID_BITS));
    bit_a     = cnt_q < {1'b0, ma_q};
    bit_b     = cnt_rev < mb_q;
    ones_d    = ones_q + {{VALID_BITS{1'b0}}, bit_a & bit_b};
    run_limit = (EARLY_TERM != 0) ? {1'b0, ma_q} : (VALID_BITS + 1)'(STREAM_LEN);
    last_run  = (cnt_q + CNT_ONE) == run_limit;
    // The count is scaled back by the total normalisation; small operands shift right.
    shift_amt = SHIFT_BASE - int'(lza_q) - int'(lzb_q);
    if (shift_amt >= 0) result_d = OUT_WIDTH'(ones_d) << shift_amt;
    else                result_d = OUT_WIDTH'(ones_d) >> (-shift_amt);
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE and out_valid only in OUT, so the two never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      lza_q       <= '0;
      lzb_q       <= '0;
      cnt_q       <= '0;
      ones_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            in_ready_q <= 1'b0;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          lza_q  <= lza_d;
          lzb_q  <= lzb_d;
          ma_q   <= ma_d;
          mb_q   <= mb_d;
          cnt_q  <= '0;
          ones_q <= '0;
          if (a_q == '0 || b_q == '0) begin
            result_q    <= '0;
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          cnt_q  <= cnt_q + CNT_ONE;
          ones_q <= ones_d;
          if (last_run) begin
            result_q    <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_result  = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sc_mul_seq.sv
// Bench for sc_mul_seq: one default instance and one early-terminating instance, with
// directed operands, hand-computed products and latencies, and a queue-based scoreboard.
module tb_sc_mul_seq;
  import sc_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b1;
  logic [15:0] a0 = '0, b0 = '0;
  logic [W-1:0] res0;
  sc_state_e dbg0;

  logic in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
  logic [15:0] a1 = '0, b1 = '0;
  logic [W-1:0] res1;
  sc_state_e dbg1;

  logic [W-1:0] exp_q0[$], exp_q1[$];
  int lat_q0[$], lat_q1[$];

  int tests = 0;
  int fails = 0;

  sc_mul_seq #(.DATA_WIDTH(16), .VALID_BITS(6), .EARLY_TERM(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(a0), .in_b(b0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_result(res0), .dbg_state_o(dbg0)
  );

  sc_mul_seq #(.DATA_WIDTH(16), .VALID_BITS(6), .EARLY_TERM(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(a1), .in_b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_result(res1), .dbg_state_o(dbg1)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: latency counts rising edges from the acceptance cycle.
  int lat0 = 0, lat1 = 0;
  bit seen0 = 0, seen1 = 0;
  logic [W-1:0] cur0 = '0, cur1 = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      seen0 = 0;
    end else begin
      lat0++;
      if (in_valid0 && in_ready0) lat0 = 0;
      if (out_valid0) begin
        if (!seen0) begin
          if (exp_q0.size() == 0) begin
            chk("u0_unexpected_output", res0, 32'hDEAD_BEEF);
          end else begin
            cur0 = exp_q0.pop_front();
            chk("u0_result", res0, cur0);
            chk("u0_latency", 32'(lat0), 32'(lat_q0.pop_front()));
            seen0 = 1;
          end
        end else begin
          chk("u0_result_hold", res0, cur0);
          chk("u0_in_ready_busy", 32'(in_ready0), 32'd0);
        end
        if (out_ready0) seen0 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      seen1 = 0;
    end else begin
      lat1++;
      if (in_valid1 && in_ready1) lat1 = 0;
      if (out_valid1) begin
        if (!seen1) begin
          if (exp_q1.size() == 0) begin
            chk("u1_unexpected_output", res1, 32'hDEAD_BEEF);
          end else begin
            cur1 = exp_q1.pop_front();
            chk("u1_result", res1, cur1);
            chk("u1_latency", 32'(lat1), 32'(lat_q1.pop_front()));
            seen1 = 1;
          end
        end else begin
          chk("u1_result_hold", res1, cur1);
          chk("u1_in_ready_busy", 32'(in_ready1), 32'd0);
        end
        if (out_ready1) seen1 = 0;
      end
    end
  end

  // Driver tasks: called at posedge+1, return at posedge+1.
  task automatic issue(input int u, input logic [15:0] a, input logic [15:0] b,
                       input logic [W-1:0] exp, input int lat);
    int n = 0;
    while (((u == 0) ? in_ready0 : in_ready1) !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) begin
      chk("issue_timeout", 32'(u), 32'hFFFF_FFFF);
      return;
    end
    if (u == 0) begin
      a0 = a; b0 = b; in_valid0 = 1'b1;
      exp_q0.push_back(exp); lat_q0.push_back(lat);
    end else begin
      a1 = a; b1 = b; in_valid1 = 1'b1;
      exp_q1.push_back(exp); lat_q1.push_back(lat);
    end
    @(posedge clk); #1;
    if (u == 0) in_valid0 = 1'b0;
    else        in_valid1 = 1'b0;
  endtask

  task automatic wait_done(input int u, output bit saw_run);
    int n = 0;
    bit busy;
    saw_run = 0;
    while (n < 300) begin
      busy = (u == 0) ? (exp_q0.size() != 0 || out_valid0) : (exp_q1.size() != 0 || out_valid1);
      if (!busy) break;
      if (((u == 0) ? dbg0 : dbg1) == ST_RUN) saw_run = 1;
      @(posedge clk); #1; n++;
    end
    if (n >= 300) chk("done_timeout", 32'(u), 32'hFFFF_FFFF);
    chk("idle_after_op", 32'((u == 0) ? dbg0 : dbg1), 32'(ST_IDLE));
  endtask

  task automatic run_op(input int u, input logic [15:0] a, input logic [15:0] b,
                        input logic [W-1:0] exp, input int lat);
    bit saw_run;
    issue(u, a, b, exp, lat);
    wait_done(u, saw_run);
    chk("run_state_entered", 32'(saw_run), 32'((a != 0 && b != 0) ? 1 : 0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_u0_in_ready"}, 32'(in_ready0), 32'd1);
    chk({tag, "_u0_out_valid"}, 32'(out_valid0), 32'd0);
    chk({tag, "_u0_result"}, res0, 32'd0);
    chk({tag, "_u0_state"}, 32'(dbg0), 32'(ST_IDLE));
    chk({tag, "_u1_in_ready"}, 32'(in_ready1), 32'd1);
    chk({tag, "_u1_out_valid"}, 32'(out_valid1), 32'd0);
    chk({tag, "_u1_result"}, res1, 32'd0);
  endtask

  initial begin
    int n;
    #12;
    chk_reset_outputs("por");
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Default instance: full stream of 64, out_valid at cycle 66.
    run_op(0, 16'h8000, 16'h8000, 32'h4000_0000, 66);
    run_op(0, 16'hFFFF, 16'hFFFF, 32'hFC00_0000, 66);
    run_op(0, 16'h0001, 16'h0001, 32'h0000_0001, 66);
    run_op(0, 16'h0100, 16'h8000, 32'h0080_0000, 66);
    run_op(0, 16'h8000, 16'hFFFF, 32'h8000_0000, 66);
    run_op(0, 16'h0000, 16'h1234, 32'h0000_0000, 2);
    run_op(0, 16'h1234, 16'h0000, 32'h0000_0000, 2);
    run_op(0, 16'h0000, 16'h0000, 32'h0000_0000, 2);

    // Early-terminating instance: stream length equals ma.
    run_op(1, 16'h8000, 16'h8000, 32'h4000_0000, 34);
    run_op(1, 16'hFFFF, 16'hFFFF, 32'hFC00_0000, 65);
    run_op(1, 16'hFFFF, 16'h8000, 32'h8000_0000, 65);
    run_op(1, 16'h8000, 16'hFFFF, 32'h8000_0000, 34);
    run_op(1, 16'h0000, 16'h1234, 32'h0000_0000, 2);

    // Back-pressure: result held for 10 cycles with out_ready low.
    out_ready0 = 1'b0;
    issue(0, 16'hFFFF, 16'hFFFF, 32'hFC00_0000, 66);
    n = 0;
    while (!out_valid0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) chk("bp_valid_timeout", 32'(n), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_valid_held", 32'(out_valid0), 32'd1);
    out_ready0 = 1'b1;
    begin
      bit saw_run;
      wait_done(0, saw_run);
    end

    // in_valid with other operands while busy must not disturb the result.
    issue(0, 16'h8000, 16'h8000, 32'h4000_0000, 66);
    repeat (10) @(posedge clk);
    #1;
    a0 = 16'hFFFF; b0 = 16'h0001; in_valid0 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    begin
      bit saw_run;
      wait_done(0, saw_run);
    end
    run_op(1, 16'hFFFF, 16'h8000, 32'h8000_0000, 65);

    // Asynchronous reset in the middle of RUN discards the operation.
    issue(0, 16'hFFFF, 16'hFFFF, 32'hFC00_0000, 66);
    repeat (20) @(posedge clk);
    #2;
    chk("pre_reset_state", 32'(dbg0), 32'(ST_RUN));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_run_rst");
    exp_q0.delete();
    lat_q0.delete();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 16'h8000, 16'hFFFF, 32'h8000_0000, 66);
    run_op(0, 16'h0001, 16'h0001, 32'h0000_0001, 66);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
